// File: rtl/vec_irq_ctrl_pkg.sv
// vec_irq_pkg: shared definitions for the vectored interrupt controller.
//   state_t     - controller state encoding (IDLE/PEND/ACK/GAP)
//   VW_DEFAULT  - default vector width
//   clog2       - ceiling log2, used to size source index fields
//   idx_width   - index width, never less than one bit
package vec_irq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_ACK  = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  localparam int VW_DEFAULT = 16;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // A single-source build still needs a one-bit index register.
  function automatic int idx_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/vec_irq_ctrl_if.sv
// vec_irq_ctrl_if: CPU-side vector-fetch bus of the interrupt controller.
//   virq - interrupt request to the CPU
//   istb - CPU vector-fetch strobe
//   iack - vector-valid acknowledge to the CPU
//   ivec - vector, valid while iack is high (zero otherwise)
// Modports: master = CPU side, slave = controller side.
interface vec_irq_ctrl_if #(
  parameter int VW = 16
);
  logic          virq;
  logic          istb;
  logic          iack;
  logic [VW-1:0] ivec;

  modport master (output istb, input virq, input iack, input ivec);
  modport slave  (input istb, output virq, output iack, output ivec);
endinterface

// File: rtl/vec_irq_ctrl_prio.sv
// vec_irq_prio: combinational N-input priority encoder.
//   req   - request vector, bit i = source i
//   ptr   - search start index; the first set bit at or above ptr
//           (wrapping modulo N) wins. ptr = 0 gives plain fixed priority.
//   valid - at least one request set
//   idx   - winning source index
module vec_irq_prio
  import vec_irq_pkg::*;
#(
  parameter int N  = 8,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] idx
);

  // Walk the offsets from the far end back to the pointer so that the
  // nearest set request is the last (and therefore winning) assignment.
  always_comb begin
    int j_idx;
    valid = 1'b0;
    idx   = '0;
    j_idx = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j_idx = (int'(ptr) + k) % N;
      if (req[j_idx]) begin
        valid = 1'b1;
        idx   = IW'(j_idx);
      end
    end
  end

endmodule

// File: rtl/vec_irq_ctrl.sv
// vec_irq_ctrl: vectored interrupt controller in front of the CPU.
// Arbitrates level requests from N sources, raises virq, answers the CPU
// vector fetch (istb/iack/ivec) and pulses irq_ack to the served source.
// Ports:
//   clk_p   - system clock (rising edge)
//   rst_n   - asynchronous active-low reset
//   irq_req - per-source level requests
//   irq_vec - per-source vectors, source i at [i*VW +: VW]
//   irq_ack - one-cycle grant pulse to the served source
//   cpu     - CPU fetch bus (slave side of vec_irq_ctrl_if)
// Build option: define VIC_RR_EN for rotating priority (pointer moves to
// w+1 after each completed fetch); otherwise fixed priority, index 0 first.
// Every output comes straight from a register.
module vec_irq_ctrl
  import vec_irq_pkg::*;
#(
  parameter int N  = 8,
  parameter int VW = VW_DEFAULT
) (
  input  logic            clk_p,
  input  logic            rst_n,
  input  logic [N-1:0]    irq_req,
  input  logic [N*VW-1:0] irq_vec,
  output logic [N-1:0]    irq_ack,
  vec_irq_ctrl_if.slave   cpu
);

  localparam int IW = idx_width(N);

  state_t          state_reg, state_next;
  logic [IW-1:0]   idx_reg, idx_next;
  logic [VW-1:0]   vec_reg, vec_next;
  logic            virq_reg, virq_next;
  logic            iack_reg, iack_next;
  logic [VW-1:0]   ivec_reg, ivec_next;
  logic [N-1:0]    ack_reg, ack_next;
  logic [IW-1:0]   search_ptr;
  logic            win_valid;
  logic [IW-1:0]   win_idx;
  logic [VW-1:0]   vec_arr [N];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_vec
      assign vec_arr[gi] = irq_vec[gi*VW +: VW];
    end
  endgenerate

`ifdef VIC_RR_EN
  logic [IW-1:0] ptr_reg, ptr_next;

  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) ptr_reg <= '0;
    else        ptr_reg <= ptr_next;
  end

  assign search_ptr = ptr_reg;
`else
  assign search_ptr = '0;
`endif

  vec_irq_prio #(.N(N), .IW(IW)) u_prio (
    .req   (irq_req),
    .ptr   (search_ptr),
    .valid (win_valid),
    .idx   (win_idx)
  );

  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      idx_reg   <= '0;
      vec_reg   <= '0;
      virq_reg  <= 1'b0;
      iack_reg  <= 1'b0;
      ivec_reg  <= '0;
      ack_reg   <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      vec_reg   <= vec_next;
      virq_reg  <= virq_next;
      iack_reg  <= iack_next;
      ivec_reg  <= ivec_next;
      ack_reg   <= ack_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    vec_next   = vec_reg;
    virq_next  = virq_reg;
    iack_next  = iack_reg;
    ivec_next  = ivec_reg;
    ack_next   = '0;
`ifdef VIC_RR_EN
    ptr_next   = ptr_reg;
`endif
    unique case (state_reg)
      ST_IDLE: begin
        if (win_valid) begin
          idx_next   = win_idx;
          vec_next   = vec_arr[win_idx];
          virq_next  = 1'b1;
          state_next = ST_PEND;
        end
      end
      ST_PEND: begin
        // The latched winner is held (no preemption) so the vector the
        // CPU fetches cannot change underneath it.
        if (cpu.istb) begin
          iack_next  = 1'b1;
          ivec_next  = vec_reg;
          state_next = ST_ACK;
        end else if (!irq_req[idx_reg]) begin
          virq_next  = 1'b0;
          state_next = ST_IDLE;
        end
      end
      ST_ACK: begin
        // Committed: the request may drop here and the ack still issues.
        if (!cpu.istb) begin
          iack_next  = 1'b0;
          ivec_next  = '0;
          virq_next  = 1'b0;
          ack_next   = N'(1) << idx_reg;
          state_next = ST_GAP;
`ifdef VIC_RR_EN
          ptr_next   = (idx_reg == IW'(N - 1)) ? '0 : IW'(idx_reg + 1'b1);
`endif
        end
      end
      ST_GAP: begin
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign irq_ack  = ack_reg;
  assign cpu.virq = virq_reg;
  assign cpu.iack = iack_reg;
  assign cpu.ivec = ivec_reg;

endmodule

// File: tb/tb_vec_irq_ctrl.sv
// tb_vec_irq_ctrl: directed self-checking bench for vec_irq_ctrl
// (N=8, VW=16). Expected values are hand-derived from the cycle-level
// behaviour; the rotating-priority step picks its expectations from the
// VIC_RR_EN build option.
module tb_vec_irq_ctrl;

  localparam int N  = 8;
  localparam int VW = 16;

  logic            clk_p = 1'b0;
  logic            rst_n;
  logic [N-1:0]    irq_req;
  logic [N*VW-1:0] irq_vec;
  logic [N-1:0]    irq_ack;

  logic [VW-1:0] vtab [N] = '{16'o000004, 16'o000064, 16'o000060, 16'o000070,
                              16'o000110, 16'o000124, 16'o000130, 16'o000100};

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;

  vec_irq_ctrl_if #(.VW(VW)) bus ();

  vec_irq_ctrl #(.N(N), .VW(VW)) dut (
    .clk_p   (clk_p),
    .rst_n   (rst_n),
    .irq_req (irq_req),
    .irq_vec (irq_vec),
    .irq_ack (irq_ack),
    .cpu     (bus)
  );

  always #5 clk_p = ~clk_p;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk_p);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
    $display("check %-18s observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Starts with the controller in IDLE and the source request already set.
  task automatic serve(input string tag, input int idx, input bit drop);
    tick();
    chk({tag, "_virq"}, 32'(bus.virq), 32'd1);
    bus.istb = 1'b1;
    tick();
    chk({tag, "_iack"}, 32'(bus.iack), 32'd1);
    chk({tag, "_ivec"}, 32'(bus.ivec), 32'(vtab[idx]));
    bus.istb = 1'b0;
    tick();
    chk({tag, "_iack0"}, {bus.virq, bus.iack}, 32'd0);
    chk({tag, "_ivec0"}, 32'(bus.ivec), 32'd0);
    chk({tag, "_ack"}, 32'(irq_ack), 32'(1 << idx));
    if (drop) irq_req[idx] = 1'b0;
    tick();
    chk({tag, "_ack0"}, 32'(irq_ack), 32'd0);
  endtask

  initial begin
    int exp_idx;
    rst_n    = 1'b0;
    irq_req  = '0;
    bus.istb = 1'b0;
    for (int i = 0; i < N; i++) irq_vec[i*VW +: VW] = vtab[i];
    tick(2);
    chk("rst_virq", 32'(bus.virq), 32'd0);
    chk("rst_iack", 32'(bus.iack), 32'd0);
    chk("rst_ivec", 32'(bus.ivec), 32'd0);
    chk("rst_ack", 32'(irq_ack), 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: single request from source 2; no same-cycle virq
    irq_req = 8'b0000_0100;
    #1;
    chk("t1_nocomb", 32'(bus.virq), 32'd0);
    serve("t1", 2, 1'b1);
    tick();
    chk("t1_idle", 32'(bus.virq), 32'd0);

    // 2: fixed priority between sources 1 and 7
    irq_req = 8'b1000_0010;
    serve("t2a", 1, 1'b1);
    serve("t2b", 7, 1'b1);

    // 3: withdrawal in PEND, then a spurious strobe
    irq_req = 8'b0000_1000;
    tick();
    chk("t3_virq", 32'(bus.virq), 32'd1);
    irq_req = '0;
    tick();
    chk("t3_wdraw", 32'(bus.virq), 32'd0);
    chk("t3_noack", 32'(irq_ack), 32'd0);
    bus.istb = 1'b1;
    tick();
    chk("t3_spur1", 32'(bus.iack), 32'd0);
    tick();
    chk("t3_spur2", {bus.virq, bus.iack}, 32'd0);
    bus.istb = 1'b0;
    tick();

    // 4: source 0 arrives while source 5 is pending; no preemption
    irq_req = 8'b0010_0000;
    tick();
    chk("t4_virq", 32'(bus.virq), 32'd1);
    irq_req[0] = 1'b1;
    tick();
    bus.istb = 1'b1;
    tick();
    chk("t4_ivec", 32'(bus.ivec), 32'(vtab[5]));
    bus.istb = 1'b0;
    tick();
    chk("t4_ack", 32'(irq_ack), 32'b0010_0000);
    irq_req[5] = 1'b0;
    tick();
    serve("t4b", 0, 1'b1);

    // 5: asynchronous reset while in ACK, then re-arbitration
    irq_req = 8'b0000_0100;
    tick();
    bus.istb = 1'b1;
    tick();
    chk("t5_iack", 32'(bus.iack), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async", {bus.virq, bus.iack}, 32'd0);
    chk("t5_asyncv", 32'(bus.ivec), 32'd0);
    bus.istb = 1'b0;
    tick();
    chk("t5_noack", 32'(irq_ack), 32'd0);
    rst_n = 1'b1;
    serve("t5b", 2, 1'b1);

    // 6: all sources held; rotating vs fixed priority
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    irq_req = 8'hFF;
    for (int k = 0; k < 4; k++) begin
`ifdef VIC_RR_EN
      exp_idx = k;
`else
      exp_idx = 0;
`endif
      serve($sformatf("t6_%0d", k), exp_idx, 1'b0);
    end
    irq_req = '0;
    tick(3);
    chk("t6_end", {bus.virq, bus.iack}, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
